// File: rtl/simple_buffer_arbiter_if.sv
// Bus between several writers, the shared single-entry buffer and its reader.
// The writers and the reader sit on the master side; the buffer is the slave.
interface simple_buffer_arbiter_if #(
  parameter int WIDTH      = 8,
  parameter int REQUESTERS = 4
);
  localparam int INDEX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [REQUESTERS-1:0]       write_request;
  logic [REQUESTERS*WIDTH-1:0] write_data;
  logic [REQUESTERS-1:0]       write_grant;
  logic                        full;
  logic                        empty;
  logic                        read_enable;
  logic [WIDTH-1:0]            read_data;
  logic [INDEX_WIDTH-1:0]      read_source;

  modport master (
    output write_request, write_data, read_enable,
    input  write_grant, full, empty, read_data, read_source
  );

  modport slave (
    input  write_request, write_data, read_enable,
    output write_grant, full, empty, read_data, read_source
  );
endinterface

// File: rtl/simple_buffer_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer (wrapping), and moves the pointer just past each winner.
module round_robin_arbiter #(
  parameter int REQUESTERS = 4,
  localparam int INDEX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [REQUESTERS-1:0]  requests_i,
  input  logic                   enable_i,
  output logic [REQUESTERS-1:0]  grant_o,
  output logic [INDEX_WIDTH-1:0] grant_index_o
);
  logic [INDEX_WIDTH-1:0] ptr_q;
  logic [INDEX_WIDTH-1:0] ptr_d;
  logic [INDEX_WIDTH-1:0] sel;
  logic                   found;
  int                     pos;

  // Scan upward from the pointer and grant the first active request.
  always_comb begin
    grant_o       = '0;
    grant_index_o = '0;
    found         = 1'b0;
    sel           = '0;
    pos           = 0;
    if (enable_i) begin
      for (int k = 0; k < REQUESTERS; k++) begin
        pos = (int'(ptr_q) + k) % REQUESTERS;
        sel = INDEX_WIDTH'(pos);
        if (!found && requests_i[sel]) begin
          found         = 1'b1;
          grant_o[sel]  = 1'b1;
          grant_index_o = sel;
        end
      end
    end
  end

  // Next pointer is one past the winner, wrapping at the top index.
  always_comb begin
    ptr_d = (grant_index_o == INDEX_WIDTH'(REQUESTERS - 1)) ? '0
                                                            : grant_index_o + INDEX_WIDTH'(1);
  end

  // Pointer moves only on a cycle that actually grants.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (enable_i && (|requests_i)) begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/simple_buffer_arbiter.sv
// Single-entry buffer shared by several writers through a round-robin
// arbiter. The stored word carries the index of the writer that produced it.
// A full entry blocks all grants, so write and read never share a cycle.
module simple_buffer_arbiter #(
  parameter int WIDTH      = 8,
  parameter int REQUESTERS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  simple_buffer_arbiter_if.slave   bus
);
  localparam int INDEX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [REQUESTERS-1:0]  grant;
  logic [INDEX_WIDTH-1:0] grant_index;
  logic                   full_q, full_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [INDEX_WIDTH-1:0] source_q, source_d;

  round_robin_arbiter #(
    .REQUESTERS (REQUESTERS)
  ) u_arb (
    .clock         (clock),
    .reset         (reset),
    .requests_i    (bus.write_request),
    .enable_i      (~full_q),
    .grant_o       (grant),
    .grant_index_o (grant_index)
  );

  // Capture the granted writer's word, or drain the entry on a legal read.
  always_comb begin
    full_d   = full_q;
    data_d   = data_q;
    source_d = source_q;
    if (|grant) begin
      full_d   = 1'b1;
      data_d   = bus.write_data[grant_index*WIDTH +: WIDTH];
      source_d = grant_index;
    end else if (bus.read_enable && full_q) begin
      full_d = 1'b0;
    end
  end

  // Entry state; reset drops any stored word immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q   <= 1'b0;
      data_q   <= '0;
      source_q <= '0;
    end else begin
      full_q   <= full_d;
      data_q   <= data_d;
      source_q <= source_d;
    end
  end

  // Reading an empty entry is ignored but flagged in simulation.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(bus.read_enable && !full_q))
        else $warning("read_enable asserted while buffer empty; ignored");
    end
  end

  assign bus.write_grant = grant;
  assign bus.full        = full_q;
  assign bus.empty       = ~full_q;
  assign bus.read_data   = data_q;
  assign bus.read_source = source_q;
endmodule
